pc_branch_unit: RTL
===================

# pc_branch_unit

Programmable successor to the fixed 8-entry branch-offset lookup: holds the program counter and a writable table of DEPTH D-bit branch targets, and computes the next PC every cycle. Each table entry is used either as a signed relative offset or as an absolute target. The block adds a single-entry link register for call/return, stall handling and a wrap-around flag. It sits between instruction decode, which supplies the jump controls and table index, and instruction memory, which is addressed by `prog_ctr`.

## Interface
- `D`, 12, PC and table-entry width in bits
- `A`, 3, table index width; DEPTH = 2**A entries; A >= 3 required
- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high; takes effect on the next rising edge
- `stall`  in  1  hold PC and link register this cycle
- `jump_en`  in  1  take branch using entry `lut_raddr`
- `jump_abs`  in  1  mode: 1 = entry is absolute target, 0 = entry is signed relative offset
- `call`  in  1  as `jump_en`, and also save PC+1 to the link register
- `ret`  in  1  PC <= link register
- `lut_raddr`  in  A  table index for jump/call
- `lut_we`  in  1  write table entry
- `lut_waddr`  in  A  write index
- `lut_wdata`  in  D  write data
- `prog_ctr`  out  D  current PC (registered)
- `target`  out  D  combinational read of entry `lut_raddr`
- `link`  out  D  link register (registered)
- `pc_wrap`  out  1  registered one-cycle pulse: the last PC update wrapped modulo 2**D

## Operation
- Table reset contents: entries 0..7 = 4, 5, 15, 50, -1, -5, -15, -50 (two's complement in D bits). Entries 8..DEPTH-1 = 0.
- Table write: when `lut_we`=1, entry `lut_waddr` is updated at the clock edge. Writes are independent of `stall`.
- Read-during-write to the same index: `target` and the jump use the old value that cycle; the new value is visible from the next cycle.
- Next-PC priority, evaluated each cycle: Reset > stall > ret > (call | jump_en) > increment.
  - Reset: `prog_ctr`=0, `link`=0, `pc_wrap`=0, table restored to reset contents.
  - stall: `prog_ctr` and `link` hold; `pc_wrap`=0.
  - ret: `prog_ctr` <= `link`; `link` holds; `pc_wrap`=0.
  - jump_en or call with jump_abs=1: `prog_ctr` <= entry, read as unsigned; `pc_wrap`=0.
  - jump_en or call with jump_abs=0: `prog_ctr` <= (`prog_ctr` + sign-extended entry) mod 2**D. `pc_wrap`=1 if the true signed sum is < 0 or > 2**D-1.
  - call additionally: `link` <= (`prog_ctr`+1) mod 2**D.
  - Otherwise: `prog_ctr` <= (`prog_ctr`+1) mod 2**D. `pc_wrap`=1 if `prog_ctr` was 2**D-1.
- `call` and `jump_en` both high behaves as `call`. `ret` together with `call` or `jump_en`: `ret` wins and `link` is not updated.
- Offset 0 in relative mode is legal: the PC holds, with no wrap.

## Timing
- Latency: every control input sampled at edge N is reflected in `prog_ctr`, `link` and `pc_wrap` after edge N; one cycle.
- `target` is combinational from `lut_raddr` and the stored table, so it is valid in the same cycle.
- Reset asserted mid-operation overrides all other inputs at that edge, including `lut_we`. The first increment happens on the first edge with Reset low.
- `pc_wrap` is high for exactly one cycle per wrapping update.
- No handshake: decode must hold `stall` for every cycle the PC is to be frozen.

## Test plan
- Reset, then 5 idle cycles -> `prog_ctr` = 0,1,2,3,4,5; `link`=0; `target` at idx 7 = 0xFCE (-50).
- PC=4, relative jump idx 4 (-1) -> PC=3. Then PC=3, relative jump idx 7 (-50) -> PC=0xFD1 and `pc_wrap` pulses for one cycle.
- PC=0xFFF with increment -> PC=0 and `pc_wrap`=1. Next increment -> PC=1 and `pc_wrap`=0.
- Write idx 2 = 0x123 while `jump_abs`=1 and `jump_en` on idx 2 in the same cycle -> PC=15 (old value). Repeating the jump the next cycle -> PC=0x123.
- PC=10, call relative idx 1 (+5) -> PC=15, `link`=11. Three increments -> PC=18. Then ret -> PC=11. A ret with `stall`=1 instead -> PC holds at 18.
- Mid-run (PC=20, `link`=11, idx 0 rewritten to 100): assert Reset one cycle -> PC=0, `link`=0, `pc_wrap`=0, and idx 0 reads 4 again.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Holds the program counter and a writable table of 2**A branch targets,
//   and computes the next PC every cycle. Each table entry is used either as
//   a signed relative offset or as an absolute target. A single-entry link
//   register supports call/return.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset (PC, link, wrap flag, table)
//   i_stall      hold PC and link this cycle (table writes still happen)
//   i_jump_en    take a branch using entry i_lut_raddr
//   i_jump_abs   1 = entry is an absolute target, 0 = signed relative offset
//   i_call       as i_jump_en, and also save PC+1 to the link register
//   i_ret        PC <= link register
//   i_lut_raddr  table index for jump/call and for o_target
//   i_lut_we     table write enable
//   i_lut_waddr  table write index
//   i_lut_wdata  table write data
//   o_prog_ctr   current PC (registered)
//   o_target     combinational read of entry i_lut_raddr
//   o_link       link register (registered)
//   o_pc_wrap    one-cycle pulse: the last PC update wrapped modulo 2**D
module pc_branch_unit #(
  parameter int D = 12,
  parameter int A = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_stall,
  input  logic         i_jump_en,
  input  logic         i_jump_abs,
  input  logic         i_call,
  input  logic         i_ret,
  input  logic [A-1:0] i_lut_raddr,
  input  logic         i_lut_we,
  input  logic [A-1:0] i_lut_waddr,
  input  logic [D-1:0] i_lut_wdata,
  output logic [D-1:0] o_prog_ctr,
  output logic [D-1:0] o_target,
  output logic [D-1:0] o_link,
  output logic         o_pc_wrap
);

  localparam int DEPTH = 1 << A;

  // Reset contents: first eight entries are the legacy fixed offsets,
  // the rest are zero.
  function automatic logic [D-1:0] lut_init(input int idx);
    logic [D-1:0] v;
    case (idx)
      0:       v = D'(4);
      1:       v = D'(5);
      2:       v = D'(15);
      3:       v = D'(50);
      4:       v = D'(-1);
      5:       v = D'(-5);
      6:       v = D'(-15);
      7:       v = D'(-50);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [D-1:0]        r_lut [DEPTH];
  logic [D-1:0]        r_pc;
  logic [D-1:0]        r_link;
  logic                r_wrap;

  logic [D-1:0]        w_entry;
  logic signed [D+1:0] w_rel_sum;
  logic [D:0]          w_inc;
  logic [D-1:0]        w_pc_nxt;
  logic [D-1:0]        w_link_nxt;
  logic                w_wrap_nxt;

  // Read sees the stored table, so a same-cycle write is not visible yet.
  assign w_entry = r_lut[i_lut_raddr];

  // PC is unsigned in [0, 2**D-1] and the offset signed in D bits, so the
  // true sum fits in D+2 signed bits; either top bit set means it left range.
  assign w_rel_sum = $signed({2'b00, r_pc}) + $signed({{2{w_entry[D-1]}}, w_entry});
  assign w_inc     = {1'b0, r_pc} + (D+1)'(1);

  always_comb begin
    w_pc_nxt   = r_pc;
    w_link_nxt = r_link;
    w_wrap_nxt = 1'b0;
    if (i_stall) begin
      w_pc_nxt = r_pc;
    end else if (i_ret) begin
      w_pc_nxt = r_link;
    end else if (i_call || i_jump_en) begin
      if (i_jump_abs) begin
        w_pc_nxt = w_entry;
      end else begin
        w_pc_nxt   = w_rel_sum[D-1:0];
        w_wrap_nxt = w_rel_sum[D+1] | w_rel_sum[D];
      end
      if (i_call) begin
        w_link_nxt = w_inc[D-1:0];
      end
    end else begin
      w_pc_nxt   = w_inc[D-1:0];
      w_wrap_nxt = w_inc[D];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc   <= '0;
      r_link <= '0;
      r_wrap <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_lut[i] <= lut_init(i);
      end
    end else begin
      r_pc   <= w_pc_nxt;
      r_link <= w_link_nxt;
      r_wrap <= w_wrap_nxt;
      if (i_lut_we) begin
        r_lut[i_lut_waddr] <= i_lut_wdata;
      end
    end
  end

  assign o_prog_ctr = r_pc;
  assign o_link     = r_link;
  assign o_pc_wrap  = r_wrap;
  assign o_target   = w_entry;

endmodule
